clint_controller: RTL

- Single-hart core-local interruptor; sole master of clint_interface.
- Holds the machine timer (mtime), compare register (mtimecmp) and software-interrupt bit (msip), all memory-mapped on a simple 64-bit request/response register bus.
- Registers the PLIC external-interrupt lines before forwarding, so every interrupt output toward the core is a flop output.

---
 rtl/prv664_clint_pkg.sv | 31 +++
 rtl/clint_interface.sv | 28 ++
 rtl/clint_timer.sv | 50 +++++
 rtl/clint_controller.sv | 124 ++++++++++++
 4 files changed

// File: rtl/prv664_clint_pkg.sv
// prv664 CLINT shared definitions.
// Register offsets, reset values, FSM states, strobe merge.
package prv664_clint_pkg;

  localparam int CLINT_XLEN = 64;

  localparam int unsigned CLINT_MSIP_OFS     = 32'h0000;
  localparam int unsigned CLINT_MTIMECMP_OFS = 32'h4000;
  localparam int unsigned CLINT_MTIME_OFS    = 32'hBFF8;

  localparam logic [CLINT_XLEN-1:0] MTIMECMP_RST = '1;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } clint_state_e;

  function automatic logic [CLINT_XLEN-1:0] strb_merge(
    input logic [CLINT_XLEN-1:0] old,
    input logic [CLINT_XLEN-1:0] wd,
    input logic [7:0]            strb
  );
    logic [CLINT_XLEN-1:0] r;
    r = old;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_interface.sv
// CLINT to core interrupt bundle.
// Every signal here is driven from a flop.
interface clint_interface;
  import prv664_clint_pkg::*;

  logic                  mei;
  logic                  sei;
  logic                  msi;
  logic                  mti;
  logic [CLINT_XLEN-1:0] mtime;

  modport master (
    output mei,
    output sei,
    output msi,
    output mti,
    output mtime
  );

  modport slave (
    input mei,
    input sei,
    input msi,
    input mti,
    input mtime
  );

endinterface

// File: rtl/clint_timer.sv
// Machine timer: prescaler, mtime, mtimecmp, mti.
// mti is computed from next-state values.
module clint_timer
  import prv664_clint_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  cmp_we,
  input  logic                  mtime_we,
  input  logic [7:0]            wstrb,
  input  logic [CLINT_XLEN-1:0] wdata,
  output logic [CLINT_XLEN-1:0] mtime,
  output logic [CLINT_XLEN-1:0] mtimecmp,
  output logic                  mti
);

  logic [15:0]           presc;
  logic [15:0]           presc_n;
  logic                  tick;
  logic [CLINT_XLEN-1:0] mtime_n;
  logic [CLINT_XLEN-1:0] cmp_n;

  assign tick    = presc == 16'(TICK_DIV - 1);
  assign presc_n = tick ? 16'd0 : presc + 16'd1;

  // a bus write to mtime replaces the tick increment
  always_comb begin
    mtime_n = mtime + {{(CLINT_XLEN-1){1'b0}}, tick};
    if (mtime_we) mtime_n = strb_merge(mtime, wdata, wstrb);
    cmp_n = mtimecmp;
    if (cmp_we) cmp_n = strb_merge(mtimecmp, wdata, wstrb);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST;
      mti      <= 1'b0;
    end else begin
      presc    <= presc_n;
      mtime    <= mtime_n;
      mtimecmp <= cmp_n;
      mti      <= mtime_n >= cmp_n;
    end
  end

endmodule

// File: rtl/clint_controller.sv
// Single-hart CLINT: register bus FSM, msip, PLIC flops.
// Timer state lives in clint_timer.
module clint_controller
  import prv664_clint_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int ADDR_W   = 16,
  parameter int XLEN     = 64
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_wr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [7:0]        req_wstrb_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_err_o,
  input  logic              plic_mei_i,
  input  logic              plic_sei_i,
  clint_interface.master    clint_master
);

  clint_state_e    state;
  logic            acc;
  logic            hit_msip;
  logic            hit_cmp;
  logic            hit_mtime;
  logic            hit;
  logic            cmp_we;
  logic            mtime_we;
  logic [XLEN-1:0] mtime;
  logic [XLEN-1:0] mtimecmp;
  logic [XLEN-1:0] rd_mux;
  logic            msip;
  logic            msi_q;
  logic            mei_q;
  logic            sei_q;
  logic            mti;

  assign acc       = (state == ST_IDLE) && req_valid_i;
  assign hit_msip  = req_addr_i == ADDR_W'(CLINT_MSIP_OFS);
  assign hit_cmp   = req_addr_i == ADDR_W'(CLINT_MTIMECMP_OFS);
  assign hit_mtime = req_addr_i == ADDR_W'(CLINT_MTIME_OFS);
  assign hit       = hit_msip | hit_cmp | hit_mtime;
  assign cmp_we    = acc && req_wr_i && hit_cmp;
  assign mtime_we  = acc && req_wr_i && hit_mtime;

  clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk_i    (clk_i),
    .arst_ni  (arst_ni),
    .cmp_we   (cmp_we),
    .mtime_we (mtime_we),
    .wstrb    (req_wstrb_i),
    .wdata    (req_wdata_i),
    .mtime    (mtime),
    .mtimecmp (mtimecmp),
    .mti      (mti)
  );

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      hit_msip:  rd_mux = {{(XLEN-1){1'b0}}, msip};
      hit_cmp:   rd_mux = mtimecmp;
      hit_mtime: rd_mux = mtime;
      default:   rd_mux = '0;
    endcase
  end

  // read data is captured at acceptance, before any tick lands
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state       <= ST_IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      msip        <= 1'b0;
      msi_q       <= 1'b0;
      mei_q       <= 1'b0;
      sei_q       <= 1'b0;
    end else begin
      msi_q <= msip;
      mei_q <= plic_mei_i;
      sei_q <= plic_sei_i;
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            state       <= ST_RESP;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= ~hit;
            rsp_rdata_o <= req_wr_i ? '0 : rd_mux;
            if (req_wr_i && hit_msip && req_wstrb_i[0])
              msip <= req_wdata_i[0];
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state       <= ST_IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign clint_master.mei   = mei_q;
  assign clint_master.sei   = sei_q;
  assign clint_master.msi   = msi_q;
  assign clint_master.mti   = mti;
  assign clint_master.mtime = mtime;

endmodule
